multi_cycle_controller: RTL and testbench
=========================================

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, max data-memory wait cycles in MEM before error.
REQ-002 Parameter CNT_W, default 32, width of retired-instruction counter.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 opcode  in  6  instruction opcode from external IR; stable from the cycle after IRWr.
REQ-006 funct  in  6  R-type function field from external IR.
REQ-007 zero  in  1  ALU zero flag, valid in EX.
REQ-008 mem_ready  in  1  data-memory completion handshake.
REQ-009 PCWr  out  1  PC write enable.
REQ-010 IRWr  out  1  instruction-register write enable.
REQ-011 nPC_sel  out  1  0 = PC+4, 1 = branch target.
REQ-012 RegWr, RegDst, ExtOp, ALUSrc, MemtoReg  out  1 each  existing datapath meanings: RegDst 1 = rd; ExtOp 1 = sign; ALUSrc 1 = immediate; MemtoReg 1 = memory data.
REQ-013 ALUctr  out  3  010 add, 110 sub, 001 or, 000 idle.
REQ-014 MemRd, MemWr  out  1 each  data-memory read/write request.
REQ-015 retire  out  1  one-cycle pulse per completed instruction.
REQ-016 instret  out  CNT_W  retired-instruction count.
REQ-017 illegal  out  1  one-cycle pulse on unsupported instruction.
REQ-018 err  out  1  sticky memory-timeout error.
REQ-019 state  out  3  current FSM state, for debug.

Function
REQ-020 Supported instructions: add (op 00, funct 20), sub (op 00, funct 22), ori (op 0d), lw (op 23), sw (op 2b), beq (op 04); all others are illegal.
REQ-021 States: IF=0, ID=1, EX=2, MEM=3, WB=4, ERR=7.
REQ-022 IF: IRWr=1 for 1 cycle; next state ID.
REQ-023 ID: decode opcode/funct and latch the class into an internal register. Legal -> EX. Illegal -> illegal=1, PCWr=1, nPC_sel=0, then IF; retire not asserted.
REQ-024 EX: ALUctr/ALUSrc/ExtOp per class, with ALUctr held constant through WB. add/sub/ori -> WB; lw/sw -> MEM; beq -> PCWr=1, nPC_sel=zero, retire=1, then IF.
REQ-025 MEM: lw holds MemRd=1, sw holds MemWr=1 until mem_ready=1. On the ready cycle, lw -> WB; sw -> PCWr=1, retire=1, then IF.
REQ-026 MEM wait counter: cleared on MEM entry. If MEM_TIMEOUT cycles elapse without mem_ready -> ERR, err=1. The ready sample in cycle MEM_TIMEOUT still counts as success.
REQ-027 WB: RegWr=1; RegDst=1 for add/sub only; MemtoReg=1 for lw only; PCWr=1, nPC_sel=0, retire=1; next state IF.
REQ-028 ERR: terminal until rst; every enable (PCWr, IRWr, RegWr, MemRd, MemWr) is 0.
REQ-029 Latency from IF entry to IF re-entry, in cycles: beq 3, add/sub/ori 4, sw 4+w, lw 5+w, illegal 2 (w = extra wait cycles).
REQ-030 Enables are decoded from state plus latched class; no output latches; ALUctr defaults to 000 outside EX..WB.
REQ-031 instret increments by 1 on each retire cycle and wraps modulo 2^CNT_W.
REQ-032 mem_ready is ignored outside MEM.

Reset
REQ-033 rst asserted at any time, including mid-MEM, forces: state=IF, latched class=none, wait counter=0, instret=0, err=0.
REQ-034 While rst is high, every output is 0, including IRWr.
REQ-035 First cycle after rst deasserts is IF with IRWr=1.

Structure
REQ-036 A shared package holds:
- state encodings
- opcode/funct constants
- ALUctr codes
- instruction-class enumeration
REQ-037 A combinational sub-module mc_decode maps opcode/funct to instruction class and the illegal flag.
REQ-038 Estimated size: 150-300 lines of RTL.

Verification
REQ-039 add after reset: states IF,ID,EX,WB; WB shows RegWr=1, RegDst=1, ALUctr=010; instret=1 after 4 cycles.
REQ-040 beq with zero=1 then zero=0: EX shows PCWr=1, with nPC_sel=1 then 0; 3 cycles each; instret +2.
REQ-041 lw with mem_ready at 3rd MEM cycle: MemRd high 3 cycles; WB shows MemtoReg=1; 7 cycles total.
REQ-042 sw with mem_ready never asserted, MEM_TIMEOUT=4: err=1, state=7, all enables 0; err stays 1 until rst.
REQ-043 opcode 3f: illegal pulse in ID, PCWr=1, back to IF after 2 cycles, instret unchanged.
REQ-044 rst asserted during lw MEM wait: outputs 0 immediately, state=0, instret=0; after release, IRWr=1.

Source files
------------

// File: rtl/multi_cycle_controller_pkg.sv
// Shared definitions for the multi-cycle controller.
// Contents: FSM state encodings, opcode/funct constants, ALUctr codes, the
// instruction-class enumeration and the class-to-ALUctr mapping.
package multi_cycle_controller_pkg;

  typedef enum logic [2:0] {
    StIf  = 3'd0,
    StId  = 3'd1,
    StEx  = 3'd2,
    StMem = 3'd3,
    StWb  = 3'd4,
    StErr = 3'd7
  } state_e;

  localparam logic [5:0] OpRtype  = 6'h00;
  localparam logic [5:0] OpOri    = 6'h0d;
  localparam logic [5:0] OpLw     = 6'h23;
  localparam logic [5:0] OpSw     = 6'h2b;
  localparam logic [5:0] OpBeq    = 6'h04;
  localparam logic [5:0] FunctAdd = 6'h20;
  localparam logic [5:0] FunctSub = 6'h22;

  localparam logic [2:0] AluIdle = 3'b000;
  localparam logic [2:0] AluAdd  = 3'b010;
  localparam logic [2:0] AluSub  = 3'b110;
  localparam logic [2:0] AluOr   = 3'b001;

  typedef enum logic [2:0] {
    ClsNone,
    ClsAdd,
    ClsSub,
    ClsOri,
    ClsLw,
    ClsSw,
    ClsBeq
  } cls_e;

  // lw/sw add the offset to the base; beq compares by subtraction.
  function automatic logic [2:0] alu_ctr(cls_e cls);
    logic [2:0] ctr;
    ctr = AluIdle;
    case (cls)
      ClsAdd, ClsLw, ClsSw: ctr = AluAdd;
      ClsSub, ClsBeq:       ctr = AluSub;
      ClsOri:               ctr = AluOr;
      default:              ctr = AluIdle;
    endcase
    return ctr;
  endfunction

endpackage

// File: rtl/multi_cycle_controller_decode.sv
// mc_decode: combinational instruction decoder.
// Ports:
//   opcode  in  6  instruction opcode
//   funct   in  6  R-type function field
//   cls     out    decoded instruction class (ClsNone when unsupported)
//   illegal out 1  instruction is not supported
module mc_decode
  import multi_cycle_controller_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_e       cls,
  output logic       illegal
);

  always_comb begin
    cls = ClsNone;
    case (opcode)
      OpRtype: begin
        if (funct == FunctAdd) begin
          cls = ClsAdd;
        end else if (funct == FunctSub) begin
          cls = ClsSub;
        end
      end
      OpOri:   cls = ClsOri;
      OpLw:    cls = ClsLw;
      OpSw:    cls = ClsSw;
      OpBeq:   cls = ClsBeq;
      default: cls = ClsNone;
    endcase
    illegal = (cls == ClsNone);
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle datapath controller (IF/ID/EX/MEM/WB) with memory-wait timeout,
// retired-instruction counter and sticky error state.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   opcode, funct       instruction fields from the external IR
//   zero                ALU zero flag (used by beq in EX)
//   mem_ready           data-memory completion, sampled only in MEM
//   PCWr, IRWr, nPC_sel, RegWr, RegDst, ExtOp, ALUSrc, MemtoReg, ALUctr,
//   MemRd, MemWr        datapath controls
//   retire, instret     retire pulse and retired-instruction count
//   illegal, err        unsupported-instruction pulse, sticky timeout error
//   state               current FSM state
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWr,
  output logic             IRWr,
  output logic             nPC_sel,
  output logic             RegWr,
  output logic             RegDst,
  output logic             ExtOp,
  output logic             ALUSrc,
  output logic             MemtoReg,
  output logic [2:0]       ALUctr,
  output logic             MemRd,
  output logic             MemWr,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             illegal,
  output logic             err,
  output logic [2:0]       state
);

  // Counter holds 0..MEM_TIMEOUT-1: value k-1 during the k-th MEM cycle.
  localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  state_e             state_q;
  cls_e               cls_q;
  logic [WaitW-1:0]   wait_q;
  logic [CNT_W-1:0]   instret_q;
  logic               err_q;

  cls_e               dec_cls;
  logic               dec_illegal;

  mc_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIf;
      cls_q     <= ClsNone;
      wait_q    <= '0;
      instret_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (retire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
      case (state_q)
        StIf: state_q <= StId;
        StId: begin
          cls_q   <= dec_cls;
          state_q <= dec_illegal ? StIf : StEx;
        end
        StEx: begin
          case (cls_q)
            ClsLw, ClsSw: begin
              state_q <= StMem;
              wait_q  <= '0;
            end
            ClsBeq:  state_q <= StIf;
            default: state_q <= StWb;
          endcase
        end
        StMem: begin
          if (mem_ready) begin
            state_q <= (cls_q == ClsLw) ? StWb : StIf;
          end else if (wait_q == WaitLast) begin
            state_q <= StErr;
            err_q   <= 1'b1;
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        StWb:    state_q <= StIf;
        StErr:   state_q <= StErr;
        default: state_q <= StIf;
      endcase
    end
  end

  // Controls decode from state plus latched class; ID uses the live decoder
  // because the class is only captured at the end of ID.
  always_comb begin
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    nPC_sel  = 1'b0;
    RegWr    = 1'b0;
    RegDst   = 1'b0;
    ExtOp    = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    ALUctr   = AluIdle;
    MemRd    = 1'b0;
    MemWr    = 1'b0;
    retire   = 1'b0;
    illegal  = 1'b0;
    if (!rst) begin
      if (state_q inside {StEx, StMem, StWb}) begin
        ALUctr = alu_ctr(cls_q);
        ExtOp  = cls_q inside {ClsLw, ClsSw};
        ALUSrc = cls_q inside {ClsOri, ClsLw, ClsSw};
      end
      case (state_q)
        StIf: IRWr = 1'b1;
        StId: begin
          if (dec_illegal) begin
            illegal = 1'b1;
            PCWr    = 1'b1;
          end
        end
        StEx: begin
          if (cls_q == ClsBeq) begin
            PCWr    = 1'b1;
            nPC_sel = zero;
            retire  = 1'b1;
          end
        end
        StMem: begin
          MemRd = (cls_q == ClsLw);
          MemWr = (cls_q == ClsSw);
          if (mem_ready && cls_q == ClsSw) begin
            PCWr   = 1'b1;
            retire = 1'b1;
          end
        end
        StWb: begin
          RegWr    = 1'b1;
          RegDst   = cls_q inside {ClsAdd, ClsSub};
          MemtoReg = (cls_q == ClsLw);
          PCWr     = 1'b1;
          retire   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign instret = instret_q;
  assign err     = err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench: the driver pushes the expected output vector for every
// cycle it drives; the monitor pops and compares on each falling edge.
module tb_multi_cycle_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        PCWr, IRWr, nPC_sel, RegWr, RegDst, ExtOp, ALUSrc, MemtoReg;
  logic [2:0]  ALUctr;
  logic        MemRd, MemWr, retire, illegal, err;
  logic [31:0] instret;
  logic [2:0]  state;

  always #5 clk = ~clk;

  multi_cycle_controller #(
    .MEM_TIMEOUT (4),
    .CNT_W       (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .mem_ready (mem_ready),
    .PCWr      (PCWr),
    .IRWr      (IRWr),
    .nPC_sel   (nPC_sel),
    .RegWr     (RegWr),
    .RegDst    (RegDst),
    .ExtOp     (ExtOp),
    .ALUSrc    (ALUSrc),
    .MemtoReg  (MemtoReg),
    .ALUctr    (ALUctr),
    .MemRd     (MemRd),
    .MemWr     (MemWr),
    .retire    (retire),
    .instret   (instret),
    .illegal   (illegal),
    .err       (err),
    .state     (state)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic        pcwr, irwr, npc, regwr, regdst, extop, alusrc, memtoreg;
    logic [2:0]  alu;
    logic        memrd, memwr, ret, ill, err;
    logic [31:0] instret;
  } vec_t;

  typedef struct {
    string name;
    vec_t  v;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cnt = 0;  // expected retired count
  bit   done = 1'b0;

  // Monitor
  initial begin
    vec_t got;
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = '{st: state, pcwr: PCWr, irwr: IRWr, npc: nPC_sel, regwr: RegWr,
                regdst: RegDst, extop: ExtOp, alusrc: ALUSrc, memtoreg: MemtoReg,
                alu: ALUctr, memrd: MemRd, memwr: MemWr, ret: retire, ill: illegal,
                err: err, instret: instret};
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s: got %h required %h", e.name, got, e.v);
        end
      end
    end
  end

  function automatic vec_t base(input logic [2:0] st);
    vec_t v;
    v = '0;
    v.st = st;
    v.instret = cnt;
    return v;
  endfunction

  task automatic cyc(input string nm, input vec_t v, input logic z, input logic rdy,
                     input logic r);
    zero = z;
    mem_ready = rdy;
    rst = r;
    exp_q.push_back('{name: nm, v: v});
    @(posedge clk);
    #1;
  endtask

  task automatic if_id(input string nm, input logic [5:0] op, input logic [5:0] fn);
    vec_t v;
    opcode = op;
    funct = fn;
    v = base(3'd0);
    v.irwr = 1'b1;
    cyc({nm, " IF"}, v, 1'b0, 1'b1, 1'b0);  // mem_ready high here must be ignored
    v = base(3'd1);
    cyc({nm, " ID"}, v, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_alu(input string nm, input logic [5:0] op, input logic [5:0] fn,
                        input logic [2:0] alu, input logic src, input logic dst);
    vec_t v;
    if_id(nm, op, fn);
    v = base(3'd2);
    v.alu = alu;
    v.alusrc = src;
    cyc({nm, " EX"}, v, 1'b1, 1'b1, 1'b0);
    v = base(3'd4);
    v.alu = alu;
    v.alusrc = src;
    v.regwr = 1'b1;
    v.regdst = dst;
    v.pcwr = 1'b1;
    v.ret = 1'b1;
    cyc({nm, " WB"}, v, 1'b0, 1'b0, 1'b0);
    cnt++;
  endtask

  task automatic do_beq(input string nm, input logic z);
    vec_t v;
    if_id(nm, 6'h04, 6'h00);
    v = base(3'd2);
    v.alu = 3'b110;
    v.pcwr = 1'b1;
    v.npc = z;
    v.ret = 1'b1;
    cyc({nm, " EX"}, v, z, 1'b0, 1'b0);
    cnt++;
  endtask

  // Memory op with mem_ready arriving in MEM cycle rdy_at (1-based).
  task automatic do_mem(input string nm, input bit is_lw, input int rdy_at);
    vec_t v;
    if_id(nm, is_lw ? 6'h23 : 6'h2b, 6'h00);
    v = base(3'd2);
    v.alu = 3'b010;
    v.alusrc = 1'b1;
    v.extop = 1'b1;
    cyc({nm, " EX"}, v, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= rdy_at; k++) begin
      v = base(3'd3);
      v.alu = 3'b010;
      v.alusrc = 1'b1;
      v.extop = 1'b1;
      v.memrd = is_lw;
      v.memwr = !is_lw;
      if (k == rdy_at && !is_lw) begin
        v.pcwr = 1'b1;
        v.ret = 1'b1;
      end
      cyc($sformatf("%s MEM%0d", nm, k), v, 1'b0, k == rdy_at, 1'b0);
    end
    if (is_lw) begin
      v = base(3'd4);
      v.alu = 3'b010;
      v.alusrc = 1'b1;
      v.extop = 1'b1;
      v.regwr = 1'b1;
      v.memtoreg = 1'b1;
      v.pcwr = 1'b1;
      v.ret = 1'b1;
      cyc({nm, " WB"}, v, 1'b0, 1'b0, 1'b0);
    end
    cnt++;
  endtask

  task automatic do_illegal(input string nm, input logic [5:0] op, input logic [5:0] fn);
    vec_t v;
    opcode = op;
    funct = fn;
    v = base(3'd0);
    v.irwr = 1'b1;
    cyc({nm, " IF"}, v, 1'b0, 1'b0, 1'b0);
    v = base(3'd1);
    v.ill = 1'b1;
    v.pcwr = 1'b1;
    cyc({nm, " ID"}, v, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string nm, input int n);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      cyc($sformatf("%s rst%0d", nm, k), vec_t'(0), 1'b0, 1'b1, 1'b1);
    end
  endtask

  initial begin
    vec_t v;
    @(posedge clk);
    #1;
    do_reset("por", 2);
    do_alu("add", 6'h00, 6'h20, 3'b010, 1'b0, 1'b1);
    do_alu("sub", 6'h00, 6'h22, 3'b110, 1'b0, 1'b1);
    do_alu("ori", 6'h0d, 6'h3f, 3'b001, 1'b1, 1'b0);
    do_beq("beq_t", 1'b1);
    do_beq("beq_nt", 1'b0);
    do_mem("lw_w2", 1'b1, 3);
    do_mem("sw_w0", 1'b0, 1);
    do_mem("sw_edge", 1'b0, 4);  // ready in the last allowed cycle still succeeds
    do_illegal("ill_3f", 6'h3f, 6'h00);
    do_illegal("ill_fn", 6'h00, 6'h21);
    do_alu("add2", 6'h00, 6'h20, 3'b010, 1'b0, 1'b1);

    // Reset in the middle of a lw memory wait.
    if_id("lw_rst", 6'h23, 6'h00);
    v = base(3'd2);
    v.alu = 3'b010;
    v.alusrc = 1'b1;
    v.extop = 1'b1;
    cyc("lw_rst EX", v, 1'b0, 1'b0, 1'b0);
    v.st = 3'd3;
    v.memrd = 1'b1;
    cyc("lw_rst MEM1", v, 1'b0, 1'b0, 1'b0);
    do_reset("lw_rst", 2);
    do_alu("add3", 6'h00, 6'h20, 3'b010, 1'b0, 1'b1);

    // sw with no ready: timeout into the sticky error state.
    if_id("sw_to", 6'h2b, 6'h00);
    v = base(3'd2);
    v.alu = 3'b010;
    v.alusrc = 1'b1;
    v.extop = 1'b1;
    cyc("sw_to EX", v, 1'b0, 1'b0, 1'b0);
    v.st = 3'd3;
    v.memwr = 1'b1;
    for (int k = 1; k <= 4; k++) cyc($sformatf("sw_to MEM%0d", k), v, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      v = base(3'd7);
      v.err = 1'b1;
      cyc($sformatf("sw_to ERR%0d", k), v, 1'b1, k[0], 1'b0);
    end
    do_reset("err_rst", 1);
    v = base(3'd0);
    v.irwr = 1'b1;
    opcode = 6'h00;
    funct = 6'h20;
    cyc("post_err IF", v, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
